// File: rtl/cipher_regbank_pkg.sv
// cipher_regbank_pkg
//   Shared types and constants for the cipher register bank: run-controller
//   state encoding, CTRL/STATUS bit positions, default register map and a
//   helper used by the map-overlap elaboration check.
package cipher_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } run_state_t;

  // CTRL write bits
  localparam int CTRL_START = 0;
  localparam int CTRL_CHAIN = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_CLR   = 3;

  // STATUS read bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;
  localparam int STAT_ABT  = 3;

  // Default register map
  localparam int DEF_PT_BASE   = 'h00;
  localparam int DEF_KEY_BASE  = 'h10;
  localparam int DEF_CT_BASE   = 'h20;
  localparam int DEF_CTRL_ADDR = 'h30;
  localparam int DEF_STAT_ADDR = 'h31;
  localparam int DEF_RUNS_ADDR = 'h32;

  // True when [a_base, a_base+a_len) and [b_base, b_base+b_len) share an address.
  function automatic bit ranges_overlap(input int a_base, input int a_len,
                                        input int b_base, input int b_len);
    return (a_base < b_base + b_len) && (b_base < a_base + a_len);
  endfunction

endpackage

// File: rtl/cipher_regbank_if.sv
// cipher_regbank_if
//   Byte-wide register bus between uart_interface (master) and the register
//   bank (slave).
//   addr   register address
//   wdata  write data
//   write  one-cycle write strobe
//   rdata  read data, combinational from addr
interface cipher_regbank_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              write;
  logic [7:0]        rdata;

  modport master (output addr, output wdata, output write, input rdata);
  modport slave  (input addr, input wdata, input write, output rdata);
endinterface

// File: rtl/cipher_run_ctrl.sv
// cipher_run_ctrl
//   Run sequencer for the cipher core: launches max(RUNS,1) encryptions per
//   START, tracks done/overrun/abort flags and produces the done pulse.
//   Ports
//     clk, n_reset      clock, async active-low reset
//     i_start_req       CTRL write with START set
//     i_abort_req       CTRL write with ABORT set
//     i_clr_req         CTRL write with CLR set
//     i_data_wr         write to a PT/KEY/RUNS register
//     i_runs            RUNS register
//     i_core_eoc        end of computation from the core
//     o_busy/done/ovr/abt  status flags
//     o_core_start      start pulse to the core
//     o_done_irq        pulse one cycle after the last run completes
//     o_start_accept    START accepted from IDLE (load feed register)
//     o_eoc_accept      core result accepted (latch CT, feed back in chain mode)
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | no run active; START accepted, eoc ignored
//   ST_LAUNCH| core_start high for this single cycle
//   ST_WAIT  | waiting for core_eoc of the current run
module cipher_run_ctrl
  import cipher_regbank_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       i_start_req,
  input  logic       i_abort_req,
  input  logic       i_clr_req,
  input  logic       i_data_wr,
  input  logic [7:0] i_runs,
  input  logic       i_core_eoc,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ovr,
  output logic       o_abt,
  output logic       o_core_start,
  output logic       o_done_irq,
  output logic       o_start_accept,
  output logic       o_eoc_accept
);

  run_state_t r_state;
  run_state_t w_state_nxt;
  logic [7:0] r_cnt;
  logic       r_done;
  logic       r_ovr;
  logic       r_abt;
  logic       r_done_irq;
  logic       w_busy;
  logic       w_start_accept;
  logic       w_eoc_accept;
  logic       w_last_eoc;
  logic       w_core_start;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start_req) w_state_nxt = ST_LAUNCH;
      ST_LAUNCH: w_state_nxt = i_abort_req ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (i_abort_req)     w_state_nxt = ST_IDLE;
        else if (i_core_eoc) w_state_nxt = (r_cnt > 8'd1) ? ST_LAUNCH : ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy         = 1'b1;
    w_core_start   = 1'b0;
    w_start_accept = 1'b0;
    w_eoc_accept   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy         = 1'b0;
        w_start_accept = i_start_req;
      end
      ST_LAUNCH: w_core_start = 1'b1;
      // An abort in the same cycle as eoc discards the result.
      ST_WAIT:   w_eoc_accept = i_core_eoc & ~i_abort_req;
      default:   w_busy = 1'b0;
    endcase
  end

  assign w_last_eoc = w_eoc_accept && (r_cnt <= 8'd1);

  // CLR is applied before any set event of the same cycle, so a set wins.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_ovr      <= 1'b0;
      r_abt      <= 1'b0;
      r_done_irq <= 1'b0;
    end else begin
      if (w_start_accept)    r_cnt <= (i_runs == 8'd0) ? 8'd1 : i_runs;
      else if (w_eoc_accept) r_cnt <= r_cnt - 8'd1;

      r_done_irq <= w_last_eoc;

      if (w_start_accept)  r_done <= 1'b0;
      else if (w_last_eoc) r_done <= 1'b1;
      else if (i_clr_req)  r_done <= 1'b0;

      if (w_busy && (i_start_req || i_data_wr)) r_ovr <= 1'b1;
      else if (i_clr_req)                       r_ovr <= 1'b0;

      if (w_busy && i_abort_req) r_abt <= 1'b1;
      else if (i_clr_req)        r_abt <= 1'b0;
    end
  end

  assign o_busy         = w_busy;
  assign o_done         = r_done;
  assign o_ovr          = r_ovr;
  assign o_abt          = r_abt;
  assign o_core_start   = w_core_start;
  assign o_done_irq     = r_done_irq;
  assign o_start_accept = w_start_accept;
  assign o_eoc_accept   = w_eoc_accept;

endmodule

// File: rtl/cipher_regbank.sv
// cipher_regbank
//   Register bank and run controller between uart_interface and a block
//   cipher core with a start/eoc handshake. Holds plaintext, key, ciphertext,
//   CTRL/STATUS/RUNS registers; supports multi-run and chain mode.
//   Ports
//     clk, n_reset      clock, async active-low reset
//     bus (slave)       addr/wdata/write/rdata register bus
//     core_start        one-cycle start pulse to the core
//     core_plaintext    plaintext to the core, byte 0 in bits [7:0]
//     core_key          key to the core (live key register)
//     core_eoc          end of computation, one cycle
//     core_ciphertext   core result, valid with core_eoc
//     done_irq          one-cycle pulse when the last run completes
module cipher_regbank
  import cipher_regbank_pkg::*;
#(
  parameter int BLOCK_BYTES = 8,
  parameter int KEY_BYTES   = 12,
  parameter int ADDR_W      = 7,
  parameter int PT_BASE     = DEF_PT_BASE,
  parameter int KEY_BASE    = DEF_KEY_BASE,
  parameter int CT_BASE     = DEF_CT_BASE,
  parameter int CTRL_ADDR   = DEF_CTRL_ADDR,
  parameter int STAT_ADDR   = DEF_STAT_ADDR,
  parameter int RUNS_ADDR   = DEF_RUNS_ADDR
) (
  input  logic                     clk,
  input  logic                     n_reset,
  cipher_regbank_if.slave          bus,
  output logic                     core_start,
  output logic [8*BLOCK_BYTES-1:0] core_plaintext,
  output logic [8*KEY_BYTES-1:0]   core_key,
  input  logic                     core_eoc,
  input  logic [8*BLOCK_BYTES-1:0] core_ciphertext,
  output logic                     done_irq
);

  localparam bit MAP_BAD =
      (BLOCK_BYTES < 1) || (BLOCK_BYTES > 16) || (KEY_BYTES < 1) || (KEY_BYTES > 16) ||
      (PT_BASE + BLOCK_BYTES > 2**ADDR_W) || (KEY_BASE + KEY_BYTES > 2**ADDR_W) ||
      (CT_BASE + BLOCK_BYTES > 2**ADDR_W) ||
      ranges_overlap(PT_BASE, BLOCK_BYTES, KEY_BASE, KEY_BYTES) ||
      ranges_overlap(PT_BASE, BLOCK_BYTES, CT_BASE, BLOCK_BYTES) ||
      ranges_overlap(KEY_BASE, KEY_BYTES, CT_BASE, BLOCK_BYTES) ||
      ranges_overlap(PT_BASE, BLOCK_BYTES, CTRL_ADDR, 1) ||
      ranges_overlap(PT_BASE, BLOCK_BYTES, STAT_ADDR, 1) ||
      ranges_overlap(PT_BASE, BLOCK_BYTES, RUNS_ADDR, 1) ||
      ranges_overlap(KEY_BASE, KEY_BYTES, CTRL_ADDR, 1) ||
      ranges_overlap(KEY_BASE, KEY_BYTES, STAT_ADDR, 1) ||
      ranges_overlap(KEY_BASE, KEY_BYTES, RUNS_ADDR, 1) ||
      ranges_overlap(CT_BASE, BLOCK_BYTES, CTRL_ADDR, 1) ||
      ranges_overlap(CT_BASE, BLOCK_BYTES, STAT_ADDR, 1) ||
      ranges_overlap(CT_BASE, BLOCK_BYTES, RUNS_ADDR, 1) ||
      (CTRL_ADDR == STAT_ADDR) || (CTRL_ADDR == RUNS_ADDR) || (STAT_ADDR == RUNS_ADDR);

  if (MAP_BAD) begin : g_map_check
    $error("cipher_regbank: register map invalid (overlap, size or address width)");
  end

  logic [7:0]               r_pt  [BLOCK_BYTES];
  logic [7:0]               r_key [KEY_BYTES];
  logic [8*BLOCK_BYTES-1:0] r_ct;
  logic [8*BLOCK_BYTES-1:0] r_feed;
  logic [7:0]               r_runs;
  logic                     r_chain;

  logic [8*BLOCK_BYTES-1:0] w_pt_flat;
  logic [8*KEY_BYTES-1:0]   w_key_flat;
  logic [7:0]               w_rdata;
  logic                     w_pt_hit;
  logic                     w_key_hit;
  logic                     w_ctrl_hit;
  logic                     w_runs_hit;
  logic                     w_ctrl_wr;
  logic                     w_data_wr;
  logic                     w_busy;
  logic                     w_done;
  logic                     w_ovr;
  logic                     w_abt;
  logic                     w_start_accept;
  logic                     w_eoc_accept;

  assign w_ctrl_hit = (bus.addr == ADDR_W'(CTRL_ADDR));
  assign w_runs_hit = (bus.addr == ADDR_W'(RUNS_ADDR));
  assign w_ctrl_wr  = bus.write & w_ctrl_hit;
  assign w_data_wr  = bus.write & (w_pt_hit | w_key_hit | w_runs_hit);

  always_comb begin
    w_pt_hit  = 1'b0;
    w_key_hit = 1'b0;
    w_rdata   = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (bus.addr == ADDR_W'(PT_BASE + i)) begin
        w_pt_hit = 1'b1;
        w_rdata  = r_pt[i];
      end
      if (bus.addr == ADDR_W'(CT_BASE + i)) w_rdata = r_ct[8*i +: 8];
    end
    for (int i = 0; i < KEY_BYTES; i++) begin
      if (bus.addr == ADDR_W'(KEY_BASE + i)) begin
        w_key_hit = 1'b1;
        w_rdata   = r_key[i];
      end
    end
    if (w_ctrl_hit) w_rdata = {6'b0, r_chain, 1'b0};
    if (bus.addr == ADDR_W'(STAT_ADDR)) w_rdata = {4'b0, w_abt, w_ovr, w_done, w_busy};
    if (w_runs_hit) w_rdata = r_runs;
  end

  assign bus.rdata = w_rdata;

  always_comb begin
    w_pt_flat = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) w_pt_flat[8*i +: 8] = r_pt[i];
  end

  always_comb begin
    w_key_flat = '0;
    for (int i = 0; i < KEY_BYTES; i++) w_key_flat[8*i +: 8] = r_key[i];
  end

  // Configuration writes land only while idle; the run controller flags the
  // dropped ones as overruns.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < BLOCK_BYTES; i++) r_pt[i] <= '0;
      for (int i = 0; i < KEY_BYTES; i++)   r_key[i] <= '0;
      r_ct    <= '0;
      r_feed  <= '0;
      r_runs  <= '0;
      r_chain <= 1'b0;
    end else begin
      if (bus.write && !w_busy) begin
        for (int i = 0; i < BLOCK_BYTES; i++)
          if (bus.addr == ADDR_W'(PT_BASE + i)) r_pt[i] <= bus.wdata;
        for (int i = 0; i < KEY_BYTES; i++)
          if (bus.addr == ADDR_W'(KEY_BASE + i)) r_key[i] <= bus.wdata;
        if (w_runs_hit) r_runs  <= bus.wdata;
        if (w_ctrl_hit) r_chain <= bus.wdata[CTRL_CHAIN];
      end
      if (w_start_accept)                r_feed <= w_pt_flat;
      else if (w_eoc_accept && r_chain)  r_feed <= core_ciphertext;
      if (w_eoc_accept) r_ct <= core_ciphertext;
    end
  end

  cipher_run_ctrl u_run_ctrl (
    .clk            (clk),
    .n_reset        (n_reset),
    .i_start_req    (w_ctrl_wr & bus.wdata[CTRL_START]),
    .i_abort_req    (w_ctrl_wr & bus.wdata[CTRL_ABORT]),
    .i_clr_req      (w_ctrl_wr & bus.wdata[CTRL_CLR]),
    .i_data_wr      (w_data_wr),
    .i_runs         (r_runs),
    .i_core_eoc     (core_eoc),
    .o_busy         (w_busy),
    .o_done         (w_done),
    .o_ovr          (w_ovr),
    .o_abt          (w_abt),
    .o_core_start   (core_start),
    .o_done_irq     (done_irq),
    .o_start_accept (w_start_accept),
    .o_eoc_accept   (w_eoc_accept)
  );

  assign core_plaintext = r_feed;
  assign core_key       = w_key_flat;

endmodule

// File: tb/tb_cipher_regbank.sv
module tb_cipher_regbank;

  localparam int BB = 8;
  localparam int KB = 12;
  localparam logic [6:0] A_PT   = 7'h00;
  localparam logic [6:0] A_KEY  = 7'h10;
  localparam logic [6:0] A_CT   = 7'h20;
  localparam logic [6:0] A_CTRL = 7'h30;
  localparam logic [6:0] A_STAT = 7'h31;
  localparam logic [6:0] A_RUNS = 7'h32;

  logic           clk;
  logic           n_reset;
  logic           core_start;
  logic [63:0]    core_plaintext;
  logic [95:0]    core_key;
  logic           core_eoc;
  logic [63:0]    core_ciphertext;
  logic           done_irq;

  cipher_regbank_if #(.ADDR_W(7)) bus ();

  cipher_regbank dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .bus             (bus),
    .core_start      (core_start),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .core_eoc        (core_eoc),
    .core_ciphertext (core_ciphertext),
    .done_irq        (done_irq)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Observed core activity
  int          n_start = 0;
  int          n_irq = 0;
  logic [63:0] obs_pt[$];

  always @(negedge clk) begin
    if (core_start) begin
      n_start++;
      obs_pt.push_back(core_plaintext);
    end
    if (done_irq) n_irq++;
  end

  // Reference model: register contents and run bookkeeping
  logic [7:0]  m_pt[BB];
  logic [7:0]  m_key[KB];
  logic [63:0] m_ct;
  logic [63:0] m_feed;
  logic [7:0]  m_runs;
  logic        m_chain, m_busy, m_done, m_ovr, m_abt;
  int          m_left, m_starts, m_irqs;
  logic [63:0] exp_pt[$];

  function automatic logic [63:0] pt_word();
    logic [63:0] w;
    for (int i = 0; i < BB; i++) w[8*i +: 8] = m_pt[i];
    return w;
  endfunction

  function automatic logic [95:0] key_word();
    logic [95:0] w;
    for (int i = 0; i < KB; i++) w[8*i +: 8] = m_key[i];
    return w;
  endfunction

  function automatic logic [7:0] exp_status();
    return {4'b0, m_abt, m_ovr, m_done, m_busy};
  endfunction

  function automatic logic [7:0] exp_rdata(input int a);
    logic [63:0] ct;
    ct = m_ct;
    if (a >= int'(A_PT) && a < int'(A_PT) + BB)   return m_pt[a - int'(A_PT)];
    if (a >= int'(A_KEY) && a < int'(A_KEY) + KB) return m_key[a - int'(A_KEY)];
    if (a >= int'(A_CT) && a < int'(A_CT) + BB)   return ct[8*(a - int'(A_CT)) +: 8];
    if (a == int'(A_CTRL)) return {6'b0, m_chain, 1'b0};
    if (a == int'(A_STAT)) return exp_status();
    if (a == int'(A_RUNS)) return m_runs;
    return 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < BB; i++) m_pt[i] = 8'h00;
    for (int i = 0; i < KB; i++) m_key[i] = 8'h00;
    m_ct = '0; m_feed = '0; m_runs = '0;
    m_chain = 0; m_busy = 0; m_done = 0; m_ovr = 0; m_abt = 0; m_left = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: optional register write and/or core_eoc, then model update.
  task automatic step(input bit w, input logic [6:0] a, input logic [7:0] d,
                      input bit e, input logic [63:0] ct);
    bit busy0;
    int ai;
    bus.addr = a; bus.wdata = d; bus.write = w;
    core_eoc = e; core_ciphertext = ct;
    tick();
    bus.write = 1'b0; core_eoc = 1'b0;
    busy0 = m_busy;
    ai = int'(a);
    if (w) begin
      if (a == A_CTRL) begin
        if (!busy0) m_chain = d[1];
        if (d[3]) begin m_done = 0; m_ovr = 0; m_abt = 0; end
        if (busy0) begin
          if (d[0]) m_ovr = 1;
          if (d[2]) begin m_busy = 0; m_abt = 1; end
        end else if (d[0]) begin
          m_busy = 1; m_done = 0;
          m_left = (m_runs == 0) ? 1 : int'(m_runs);
          m_feed = pt_word();
          exp_pt.push_back(m_feed);
          m_starts++;
        end
      end else if ((ai < BB) || (ai >= 16 && ai < 16 + KB) || a == A_RUNS) begin
        if (busy0) m_ovr = 1;
        else if (ai < BB) m_pt[ai] = d;
        else if (a == A_RUNS) m_runs = d;
        else m_key[ai - 16] = d;
      end
    end
    if (e && busy0 && m_busy) begin
      m_ct = ct;
      if (m_chain) m_feed = ct;
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_irqs++;
      end else begin
        exp_pt.push_back(m_feed);
        m_starts++;
      end
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, core_ciphertext);
  endtask

  task automatic eoc(input logic [63:0] ct);
    step(1'b0, 7'h7F, 8'h00, 1'b1, ct);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 7'h7F, 8'h00, 1'b0, core_ciphertext);
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    n_reset = 1'b0; bus.addr = '0; bus.wdata = '0; bus.write = 1'b0;
    core_eoc = 1'b0; core_ciphertext = '0;
    model_clear();
    m_starts = 0; m_irqs = 0;
    repeat (3) tick();
    n_reset = 1'b1;
    tick();
    rd(A_STAT, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_status got=%h exp=00", d); end
    rd(A_CTRL, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_ctrl got=%h exp=00", d); end
    rd(A_CT, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_ct0 got=%h exp=00", d); end
    vectors++;
    if (core_start !== 1'b0 || done_irq !== 1'b0) begin
      miscompares++; $display("FAIL reset_outputs got start=%b irq=%b exp 0 0", core_start, done_irq);
    end
  endtask

  task automatic test_reg_random();
    logic [7:0] d;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0:       wr(7'($urandom_range(0, BB - 1)), 8'($urandom));
        1:       wr(7'(16 + $urandom_range(0, KB - 1)), 8'($urandom));
        2:       wr(A_RUNS, 8'($urandom));
        3:       wr(7'(32 + $urandom_range(0, BB - 1)), 8'($urandom));
        default: wr(7'($urandom_range(51, 127)), 8'($urandom));
      endcase
    end
    for (int a = 0; a < 128; a++) begin
      rd(7'(a), d);
      vectors++;
      if (d !== exp_rdata(a)) begin
        miscompares++; $display("FAIL regmap_readback addr=%h got=%h exp=%h", a, d, exp_rdata(a));
      end
    end
    vectors++;
    if (core_key !== key_word()) begin
      miscompares++; $display("FAIL live_key got=%h exp=%h", core_key, key_word());
    end
  endtask

  task automatic test_single_run();
    logic [7:0] d;
    for (int i = 0; i < BB; i++) wr(7'(i), 8'(i));
    for (int i = 0; i < KB; i++) wr(7'(16 + i), 8'(i));
    wr(A_RUNS, 8'h00);
    wr(A_CTRL, 8'h01);
    vectors++;
    if (core_start !== 1'b1 || core_plaintext !== 64'h0706050403020100) begin
      miscompares++; $display("FAIL single_start got start=%b pt=%h exp 1 0706050403020100", core_start, core_plaintext);
    end
    vectors++;
    if (core_key !== 96'h0B0A09080706050403020100) begin
      miscompares++; $display("FAIL single_key got=%h exp=0b0a09080706050403020100", core_key);
    end
    idle(1);
    vectors++; if (core_start !== 1'b0) begin miscompares++; $display("FAIL single_start_width got=%b exp=0", core_start); end
    idle(19);
    eoc(64'hDEADBEEF01234567);
    vectors++; if (done_irq !== 1'b1) begin miscompares++; $display("FAIL single_irq_latency got=%b exp=1", done_irq); end
    rd(A_CT, d);
    vectors++; if (d !== 8'h67) begin miscompares++; $display("FAIL single_ct0 got=%h exp=67", d); end
    rd(A_CT + 7'd7, d);
    vectors++; if (d !== 8'hDE) begin miscompares++; $display("FAIL single_ct7 got=%h exp=de", d); end
    rd(A_STAT, d);
    vectors++; if (d !== 8'h02 || d !== exp_status()) begin miscompares++; $display("FAIL single_status got=%h exp=02", d); end
    idle(2);
    vectors++;
    if (n_start !== m_starts || n_irq !== m_irqs) begin
      miscompares++; $display("FAIL single_counts got starts=%0d irqs=%0d exp %0d %0d", n_start, n_irq, m_starts, m_irqs);
    end
  endtask

  task automatic test_chain();
    logic [7:0] d;
    logic [63:0] ct;
    wr(A_RUNS, 8'd3);
    wr(A_CTRL, 8'h03);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (core_start !== 1'b1) begin miscompares++; $display("FAIL chain_start run=%0d got=%b exp=1", k, core_start); end
      idle($urandom_range(2, 8));
      rd(A_STAT, d);
      vectors++;
      if (d !== exp_status()) begin miscompares++; $display("FAIL chain_status run=%0d got=%h exp=%h", k, d, exp_status()); end
      ct = {$urandom, $urandom};
      eoc(ct);
    end
    idle(2);
    rd(A_STAT, d);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL chain_done got=%h exp=02", d); end
    vectors++;
    if (n_start !== m_starts || n_irq !== m_irqs) begin
      miscompares++; $display("FAIL chain_counts got starts=%0d irqs=%0d exp %0d %0d", n_start, n_irq, m_starts, m_irqs);
    end
    for (int i = 0; i < BB; i++) begin
      rd(7'(32 + i), d);
      vectors++;
      if (d !== exp_rdata(32 + i)) begin miscompares++; $display("FAIL chain_ct byte=%0d got=%h exp=%h", i, d, exp_rdata(32 + i)); end
    end
    vectors++;
    if (obs_pt.size() != exp_pt.size()) begin
      miscompares++; $display("FAIL chain_pt_count got=%0d exp=%0d", obs_pt.size(), exp_pt.size());
    end
    while (obs_pt.size() > 0 && exp_pt.size() > 0) begin
      logic [63:0] o, x;
      o = obs_pt.pop_front(); x = exp_pt.pop_front();
      vectors++;
      if (o !== x) begin miscompares++; $display("FAIL chain_plaintext got=%h exp=%h", o, x); end
    end
    obs_pt.delete(); exp_pt.delete();
    wr(A_CTRL, 8'h00);
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    wr(A_CTRL, 8'h08);
    wr(A_RUNS, 8'd1);
    wr(A_CTRL, 8'h01);
    idle(1);
    wr(A_CTRL, 8'h01);
    wr(A_PT, 8'hAA);
    wr(7'(16 + $urandom_range(0, KB - 1)), 8'($urandom));
    idle(2);
    vectors++; if (n_start !== m_starts) begin miscompares++; $display("FAIL ovr_no_restart got=%0d exp=%0d", n_start, m_starts); end
    rd(A_PT, d);
    vectors++; if (d !== 8'h00 || d !== exp_rdata(0)) begin miscompares++; $display("FAIL ovr_pt_kept got=%h exp=00", d); end
    vectors++; if (core_key !== key_word()) begin miscompares++; $display("FAIL ovr_key_kept got=%h exp=%h", core_key, key_word()); end
    rd(A_STAT, d);
    vectors++; if (d !== 8'h05) begin miscompares++; $display("FAIL ovr_status got=%h exp=05", d); end
    wr(A_CTRL, 8'h08);
    rd(A_STAT, d);
    vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL ovr_clr_busy got=%h exp=01", d); end
    wr(A_CTRL, 8'h02);
    rd(A_CTRL, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL ovr_chain_dropped got=%h exp=00", d); end
    eoc({$urandom, $urandom});
    rd(A_STAT, d);
    vectors++; if (d !== exp_status()) begin miscompares++; $display("FAIL ovr_finish got=%h exp=%h", d, exp_status()); end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    int irq0;
    wr(A_CTRL, 8'h08);
    wr(A_CTRL, 8'h01);
    idle(1);
    irq0 = n_irq;
    step(1'b1, A_CTRL, 8'h04, 1'b1, {$urandom, $urandom});
    rd(A_STAT, d);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL abort_status got=%h exp=08", d); end
    for (int i = 0; i < BB; i++) begin
      rd(7'(32 + i), d);
      vectors++;
      if (d !== exp_rdata(32 + i)) begin miscompares++; $display("FAIL abort_ct_kept byte=%0d got=%h exp=%h", i, d, exp_rdata(32 + i)); end
    end
    eoc({$urandom, $urandom});
    idle(2);
    vectors++; if (n_irq !== irq0) begin miscompares++; $display("FAIL abort_no_irq got=%0d exp=%0d", n_irq, irq0); end
    rd(A_CT, d);
    vectors++; if (d !== exp_rdata(32)) begin miscompares++; $display("FAIL abort_late_eoc got=%h exp=%h", d, exp_rdata(32)); end
    wr(A_CTRL, 8'h04);
    rd(A_STAT, d);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL abort_idle got=%h exp=08", d); end
    wr(A_CTRL, 8'h0D);
    vectors++; if (core_start !== 1'b1) begin miscompares++; $display("FAIL abort_start_wins got=%b exp=1", core_start); end
    rd(A_STAT, d);
    vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL clr_then_start got=%h exp=01", d); end
    idle(3);
    eoc({$urandom, $urandom});
    idle(1);
    vectors++;
    if (n_start !== m_starts || n_irq !== m_irqs) begin
      miscompares++; $display("FAIL abort_counts got starts=%0d irqs=%0d exp %0d %0d", n_start, n_irq, m_starts, m_irqs);
    end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] d;
    for (int i = 0; i < BB; i++) wr(7'(i), 8'($urandom));
    wr(A_RUNS, 8'd3);
    wr(A_CTRL, 8'h03);
    idle(2);
    eoc({$urandom, $urandom});
    idle(2);
    n_reset = 1'b0;
    model_clear();
    #1;
    step(1'b0, 7'h7F, 8'h00, 1'b1, {$urandom, $urandom});
    idle(1);
    n_reset = 1'b1;
    idle(1);
    for (int a = 0; a < 128; a++) begin
      rd(7'(a), d);
      vectors++;
      if (d !== exp_rdata(a)) begin miscompares++; $display("FAIL rst_readback addr=%h got=%h exp=%h", a, d, exp_rdata(a)); end
    end
    vectors++;
    if (core_plaintext !== 64'h0 || core_key !== 96'h0) begin
      miscompares++; $display("FAIL rst_core_buses got pt=%h key=%h exp 0 0", core_plaintext, core_key);
    end
    eoc({$urandom, $urandom});
    idle(10);
    vectors++;
    if (n_start !== m_starts || n_irq !== m_irqs) begin
      miscompares++; $display("FAIL rst_no_activity got starts=%0d irqs=%0d exp %0d %0d", n_start, n_irq, m_starts, m_irqs);
    end
    rd(A_STAT, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL rst_status got=%h exp=00", d); end
  endtask

  initial begin
    test_reset();
    test_reg_random();
    test_single_run();
    obs_pt.delete(); exp_pt.delete();
    test_chain();
    test_overrun();
    test_abort();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
